// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/load/store memory controller:
// bus widths, size codes, FSM encoding and small byte helpers.
package fetch_ctrl_pkg;

    localparam int COUNTER_LENGTH  = 1;
    localparam int RAM_ADDR_LENGTH = 16;
    localparam int MEM_A_W         = RAM_ADDR_LENGTH + 1;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int PC_W            = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [COUNTER_LENGTH:0] AIM_WORD = 2'b00;
    localparam logic [COUNTER_LENGTH:0] AIM_HALF = 2'b10;
    localparam logic [COUNTER_LENGTH:0] AIM_BYTE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Byte count of a request; the unused code 11 behaves as a word.
    function automatic logic [2:0] aim_to_len(input logic [COUNTER_LENGTH:0] aim);
        logic [2:0] len;
        case (aim)
            AIM_HALF: len = 3'd2;
            AIM_BYTE: len = 3'd1;
            default:  len = 3'd4;
        endcase
        return len;
    endfunction

    // Little-endian byte lane select.
    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] word, input logic [1:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the request, result and RAM-port signals around fetch_ctrl.
// The controller uses the slave view; the surrounding core/RAM use master.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [ADDR_W-1:0]         addr_from_slb;
    logic [DATA_W-1:0]         data_from_slb;
    logic                      is_empty_from_slb;
    logic                      is_store_from_slb;
    logic [COUNTER_LENGTH:0]   aim_from_slb;
    logic                      is_receive_from_slb;
    logic [PC_W-1:0]           pc_from_if;
    logic                      is_req_from_if;
    logic                      is_exception_from_rob;
    logic [7:0]                mem_din;

    logic                      is_stall_to_slb;
    logic [DATA_W-1:0]         data_to_core;
    logic                      is_finish_to_core;
    logic                      is_instr_to_core;
    logic [MEM_A_W-1:0]        mem_a;
    logic [7:0]                mem_dout;
    logic                      mem_wr;

    modport slave (
        input  addr_from_slb, data_from_slb, is_empty_from_slb, is_store_from_slb,
               aim_from_slb, is_receive_from_slb, pc_from_if, is_req_from_if,
               is_exception_from_rob, mem_din,
        output is_stall_to_slb, data_to_core, is_finish_to_core, is_instr_to_core,
               mem_a, mem_dout, mem_wr
    );

    modport master (
        output addr_from_slb, data_from_slb, is_empty_from_slb, is_store_from_slb,
               aim_from_slb, is_receive_from_slb, pc_from_if, is_req_from_if,
               is_exception_from_rob, mem_din,
        input  is_stall_to_slb, data_to_core, is_finish_to_core, is_instr_to_core,
               mem_a, mem_dout, mem_wr
    );

endinterface

// File: rtl/fetch_ctrl_byte_sequencer.sv
// Per-byte engine shared by reads and writes: holds the byte index, a
// terminal-count down-counter, the RAM address/data registers and the
// little-endian assembly of read bytes.
module fetch_ctrl_byte_sequencer
    import fetch_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                start_write,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [2:0]          len,
    input  logic                step,
    input  logic [7:0]          mem_din,
    output logic [MEM_A_W-1:0]  mem_a,
    output logic [7:0]          mem_dout,
    output logic                tc,
    output logic [DATA_W-1:0]   merged
);

    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] asm_q;
    logic [2:0]        len_q;
    logic [2:0]        idx;
    logic [2:0]        cnt;
    logic              write_q;

    logic [2:0]        idx_next;
    logic [ADDR_W-1:0] next_addr;
    logic [1:0]        col;
    logic              unused_addr_hi;

    // Address arithmetic wraps at 32 bits; only the RAM-sized low part leaves.
    assign idx_next       = idx + 3'd1;
    assign next_addr      = base_q + ADDR_W'(idx_next);
    assign unused_addr_hi = ^next_addr[ADDR_W-1:MEM_A_W];

    // RAM data lags the address by two edges, so the byte arriving now
    // belongs to the index issued one step earlier.
    assign col    = idx[1:0] - 2'd1;
    assign merged = asm_q | (DATA_W'(mem_din) << {col, 3'b000});
    assign tc     = (cnt == 3'd0);

    // Load on capture, then advance one byte per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            cnt      <= '0;
            write_q  <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
        end else if (start) begin
            base_q  <= base_addr;
            wdata_q <= wdata;
            asm_q   <= '0;
            len_q   <= len;
            idx     <= '0;
            write_q <= start_write;
            // Reads need one extra edge to drain the RAM latency.
            cnt     <= start_write ? (len - 3'd1) : len;
            mem_a   <= base_addr[MEM_A_W-1:0];
            if (start_write) begin
                mem_dout <= wdata[7:0];
            end
        end else if (step) begin
            idx <= idx_next;
            cnt <= cnt - 3'd1;
            if (idx_next < len_q) begin
                mem_a <= next_addr[MEM_A_W-1:0];
                if (write_q) begin
                    mem_dout <= get_byte(wdata_q, idx_next[1:0]);
                end
            end
            if (!write_q && idx != 3'd0) begin
                asm_q <= merged;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Memory-side controller: arbitrates slb data requests over instruction
// fetches, runs them as byte cycles on the single-port RAM and returns
// load/instruction results with a one-cycle finish pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for a request; slb wins over if
//   ST_READ  | issuing N addresses and collecting N bytes
//   ST_WRITE | issuing N byte writes (runs to completion on flush)
//   ST_ACK   | load result presented, waiting for slb acknowledge
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);

    state_t            state;
    logic              mem_wr_q;
    logic [DATA_W-1:0] data_q;
    logic              finish_q;
    logic              instr_out_q;
    logic              kind_instr_q;

    logic              slb_req;
    logic              capture;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_len;
    logic              seq_step;
    logic              seq_tc;
    logic [DATA_W-1:0] seq_merged;
    logic [MEM_A_W-1:0] seq_mem_a;
    logic [7:0]        seq_mem_dout;

    assign slb_req   = !bus.is_empty_from_slb;
    assign capture   = (state == ST_IDLE) && !bus.is_exception_from_rob
                       && (slb_req || bus.is_req_from_if);
    assign cap_write = slb_req && bus.is_store_from_slb;
    assign cap_addr  = slb_req ? bus.addr_from_slb : bus.pc_from_if;
    assign cap_len   = slb_req ? aim_to_len(bus.aim_from_slb) : 3'd4;

    // A flush mid-read freezes the sequencer; writes always run out.
    assign seq_step  = ((state == ST_READ) && !bus.is_exception_from_rob && !seq_tc)
                       || ((state == ST_WRITE) && !seq_tc);

    // Held high while a request is visible so slb cannot stack a second one.
    assign bus.is_stall_to_slb   = (state != ST_IDLE) || slb_req;
    assign bus.mem_wr            = mem_wr_q;
    assign bus.mem_a             = seq_mem_a;
    assign bus.mem_dout          = seq_mem_dout;
    assign bus.data_to_core      = data_q;
    assign bus.is_finish_to_core = finish_q;
    assign bus.is_instr_to_core  = instr_out_q;

    fetch_ctrl_byte_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (capture),
        .start_write (cap_write),
        .base_addr   (cap_addr),
        .wdata       (bus.data_from_slb),
        .len         (cap_len),
        .step        (seq_step),
        .mem_din     (bus.mem_din),
        .mem_a       (seq_mem_a),
        .mem_dout    (seq_mem_dout),
        .tc          (seq_tc),
        .merged      (seq_merged)
    );

    // Control FSM with registered write enable and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem_wr_q     <= FALSE;
            data_q       <= '0;
            finish_q     <= FALSE;
            instr_out_q  <= FALSE;
            kind_instr_q <= FALSE;
        end else begin
            finish_q <= FALSE;
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        kind_instr_q <= !slb_req;
                        if (cap_write) begin
                            mem_wr_q <= TRUE;
                            state    <= ST_WRITE;
                        end else begin
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.is_exception_from_rob) begin
                        state <= ST_IDLE;
                    end else if (seq_tc) begin
                        data_q      <= seq_merged;
                        finish_q    <= TRUE;
                        instr_out_q <= kind_instr_q;
                        state       <= kind_instr_q ? ST_IDLE : ST_ACK;
                    end
                end
                ST_WRITE: begin
                    if (seq_tc) begin
                        mem_wr_q <= FALSE;
                        state    <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    if (bus.is_exception_from_rob || bus.is_receive_from_slb) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a synchronous byte RAM model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]         ram [0:(1<<MEM_A_W)-1];
    logic               pre_we;
    logic [MEM_A_W-1:0] pre_addr;
    logic [7:0]         pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a];
    end

    int vectors = 0;
    int miscompares = 0;
    int fin_count = 0;
    int wr_count = 0;
    int f0, w0, e;

    always @(negedge clk) begin
        if (bus.is_finish_to_core === 1'b1) fin_count <= fin_count + 1;
        if (bus.mem_wr === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [MEM_A_W-1:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic slb_drive(input logic [31:0] a, input logic [31:0] d,
                             input logic st, input logic [1:0] aim);
        bus.addr_from_slb = a; bus.data_from_slb = d;
        bus.is_store_from_slb = st; bus.aim_from_slb = aim;
        bus.is_empty_from_slb = 1'b0;
    endtask

    task automatic wait_fin(input int max_e, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (bus.is_finish_to_core !== 1'b1 && edges < max_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.addr_from_slb = '0; bus.data_from_slb = '0;
        bus.is_empty_from_slb = 1'b1; bus.is_store_from_slb = 1'b0;
        bus.aim_from_slb = 2'b00; bus.is_receive_from_slb = 1'b0;
        bus.pc_from_if = '0; bus.is_req_from_if = 1'b0;
        bus.is_exception_from_rob = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_mem_a", 32'(bus.mem_a), 32'h0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst_data", bus.data_to_core, 32'h0);
        chk("rst_finish", 32'(bus.is_finish_to_core), 32'h0);
        chk("rst_instr", 32'(bus.is_instr_to_core), 32'h0);
        chk("rst_stall_empty", 32'(bus.is_stall_to_slb), 32'h0);
        bus.is_empty_from_slb = 1'b0;
        #1;
        chk("rst_stall_req", 32'(bus.is_stall_to_slb), 32'h1);
        bus.is_empty_from_slb = 1'b1;

        preload(17'h00100, 8'h11); preload(17'h00101, 8'h22);
        preload(17'h00102, 8'h33); preload(17'h00103, 8'h44);
        preload(17'h002FF, 8'h99); preload(17'h00300, 8'h98);
        preload(17'h00301, 8'h77);
        preload(17'h00000, 8'h93); preload(17'h00001, 8'h00);
        preload(17'h00002, 8'h10); preload(17'h00003, 8'h00);
        preload(17'h00400, 8'h00); preload(17'h00401, 8'h00);
        preload(17'h00402, 8'hEE);
        preload(17'h00500, 8'h00); preload(17'h00501, 8'h00);
        preload(17'h00502, 8'h00); preload(17'h00503, 8'h00);
        preload(17'h00600, 8'h00); preload(17'h00601, 8'h55);
        preload(17'h00602, 8'h66);
        preload(17'h1FFFE, 8'h3C); preload(17'h1FFFF, 8'hF7);
        rst = 1'b0;
        tick();

        // word load at 0x100
        f0 = fin_count;
        slb_drive(32'h100, 32'h0, 1'b0, 2'b00);
        tick();
        bus.is_empty_from_slb = 1'b1;
        chk("ld_mem_a0", 32'(bus.mem_a), 32'h100);
        chk("ld_stall_busy", 32'(bus.is_stall_to_slb), 32'h1);
        wait_fin(20, e);
        chk("ld_latency", e, 5);
        chk("ld_data", bus.data_to_core, 32'h44332211);
        chk("ld_instr", 32'(bus.is_instr_to_core), 32'h0);
        tick();
        chk("ld_pulse_width", 32'(bus.is_finish_to_core), 32'h0);
        chk("ld_ack_hold", 32'(bus.is_stall_to_slb), 32'h1);
        tick();
        chk("ld_ack_wait", 32'(bus.is_stall_to_slb), 32'h1);
        bus.is_receive_from_slb = 1'b1;
        tick();
        bus.is_receive_from_slb = 1'b0;
        chk("ld_ack_idle", 32'(bus.is_stall_to_slb), 32'h0);
        chk("ld_pulse_count", fin_count - f0, 1);

        // SH at 0x2FF
        f0 = fin_count; w0 = wr_count;
        slb_drive(32'h2FF, 32'hAABBCCDD, 1'b1, 2'b10);
        tick();
        bus.is_empty_from_slb = 1'b1;
        chk("sh_wr0", 32'(bus.mem_wr), 32'h1);
        chk("sh_a0", 32'(bus.mem_a), 32'h2FF);
        chk("sh_d0", 32'(bus.mem_dout), 32'hDD);
        tick();
        chk("sh_wr1", 32'(bus.mem_wr), 32'h1);
        chk("sh_a1", 32'(bus.mem_a), 32'h300);
        chk("sh_d1", 32'(bus.mem_dout), 32'hCC);
        tick();
        chk("sh_wr_drop", 32'(bus.mem_wr), 32'h0);
        chk("sh_idle", 32'(bus.is_stall_to_slb), 32'h0);
        tick();
        chk("sh_ram_2ff", 32'(ram[17'h2FF]), 32'hDD);
        chk("sh_ram_300", 32'(ram[17'h300]), 32'hCC);
        chk("sh_ram_301", 32'(ram[17'h301]), 32'h77);
        chk("sh_wr_cycles", wr_count - w0, 2);
        chk("sh_no_pulse", fin_count - f0, 0);

        // data and fetch in the same cycle: LBU 0x2FF first, then fetch pc 0
        f0 = fin_count;
        slb_drive(32'h2FF, 32'h0, 1'b0, 2'b01);
        bus.pc_from_if = 32'h0; bus.is_req_from_if = 1'b1;
        tick();
        bus.is_empty_from_slb = 1'b1;
        wait_fin(20, e);
        chk("arb_ld_latency", e, 2);
        chk("arb_ld_data", bus.data_to_core, 32'h000000DD);
        chk("arb_ld_instr", 32'(bus.is_instr_to_core), 32'h0);
        bus.is_receive_from_slb = 1'b1;
        tick();
        bus.is_receive_from_slb = 1'b0;
        wait_fin(20, e);
        chk("arb_if_latency", e, 6);
        chk("arb_if_data", bus.data_to_core, 32'h00100093);
        chk("arb_if_instr", 32'(bus.is_instr_to_core), 32'h1);
        bus.is_req_from_if = 1'b0;
        tick(); tick(); tick();
        chk("arb_if_idle", 32'(bus.is_stall_to_slb), 32'h0);
        chk("arb_pulse_count", fin_count - f0, 2);

        // back-to-back SBs
        w0 = wr_count;
        slb_drive(32'h400, 32'h5A, 1'b1, 2'b01);
        tick();
        slb_drive(32'h401, 32'hA5, 1'b1, 2'b01);
        chk("sb1_wr", 32'(bus.mem_wr), 32'h1);
        chk("sb1_a", 32'(bus.mem_a), 32'h400);
        chk("sb_stall_busy", 32'(bus.is_stall_to_slb), 32'h1);
        tick();
        chk("sb_gap_wr", 32'(bus.mem_wr), 32'h0);
        chk("sb_gap_stall", 32'(bus.is_stall_to_slb), 32'h1);
        tick();
        bus.is_empty_from_slb = 1'b1;
        chk("sb2_wr", 32'(bus.mem_wr), 32'h1);
        chk("sb2_a", 32'(bus.mem_a), 32'h401);
        chk("sb2_d", 32'(bus.mem_dout), 32'hA5);
        tick();
        chk("sb2_done", 32'(bus.mem_wr), 32'h0);
        chk("sb2_idle", 32'(bus.is_stall_to_slb), 32'h0);
        tick();
        chk("sb_ram_400", 32'(ram[17'h400]), 32'h5A);
        chk("sb_ram_401", 32'(ram[17'h401]), 32'hA5);
        chk("sb_ram_402", 32'(ram[17'h402]), 32'hEE);
        chk("sb_wr_cycles", wr_count - w0, 2);

        // exception during word fetch after 2 bytes read
        f0 = fin_count;
        bus.pc_from_if = 32'h0; bus.is_req_from_if = 1'b1;
        tick(); tick(); tick(); tick();
        bus.is_exception_from_rob = 1'b1; bus.is_req_from_if = 1'b0;
        tick();
        bus.is_exception_from_rob = 1'b0;
        chk("fx_idle", 32'(bus.is_stall_to_slb), 32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("fx_no_pulse", fin_count - f0, 0);
        chk("fx_data_kept", bus.data_to_core, 32'h00100093);

        // exception during SW: all bytes still written
        w0 = wr_count;
        slb_drive(32'h500, 32'h87654321, 1'b1, 2'b00);
        tick();
        bus.is_empty_from_slb = 1'b1;
        bus.is_exception_from_rob = 1'b1;
        tick(); tick();
        bus.is_exception_from_rob = 1'b0;
        tick(); tick();
        chk("swx_done", 32'(bus.mem_wr), 32'h0);
        chk("swx_idle", 32'(bus.is_stall_to_slb), 32'h0);
        tick();
        chk("swx_ram_500", 32'(ram[17'h500]), 32'h21);
        chk("swx_ram_501", 32'(ram[17'h501]), 32'h43);
        chk("swx_ram_502", 32'(ram[17'h502]), 32'h65);
        chk("swx_ram_503", 32'(ram[17'h503]), 32'h87);
        chk("swx_wr_cycles", wr_count - w0, 4);

        // exception in IDLE blocks capture
        w0 = wr_count;
        bus.is_exception_from_rob = 1'b1;
        slb_drive(32'h402, 32'h11, 1'b1, 2'b01);
        tick();
        chk("idlex_no_wr", 32'(bus.mem_wr), 32'h0);
        bus.is_empty_from_slb = 1'b1;
        bus.is_exception_from_rob = 1'b0;
        tick();
        chk("idlex_ram_402", 32'(ram[17'h402]), 32'hEE);
        chk("idlex_wr_cycles", wr_count - w0, 0);

        // LBU at top of RAM
        slb_drive(32'h1FFFF, 32'h0, 1'b0, 2'b01);
        tick();
        bus.is_empty_from_slb = 1'b1;
        chk("lbu_top_a", 32'(bus.mem_a), 32'h1FFFF);
        wait_fin(20, e);
        chk("lbu_top_latency", e, 2);
        chk("lbu_top_data", bus.data_to_core, 32'h000000F7);
        bus.is_receive_from_slb = 1'b1;
        tick();
        bus.is_receive_from_slb = 1'b0;

        // word read crossing the top address
        slb_drive(32'h1FFFE, 32'h0, 1'b0, 2'b00);
        tick();
        bus.is_empty_from_slb = 1'b1;
        chk("wrap_a0", 32'(bus.mem_a), 32'h1FFFE);
        tick();
        chk("wrap_a1", 32'(bus.mem_a), 32'h1FFFF);
        tick();
        chk("wrap_a2", 32'(bus.mem_a), 32'h0);
        wait_fin(20, e);
        chk("wrap_latency", e, 3);
        chk("wrap_data", bus.data_to_core, 32'h0093F73C);
        bus.is_receive_from_slb = 1'b1;
        tick();
        bus.is_receive_from_slb = 1'b0;

        // reset in the middle of a SW
        f0 = fin_count; w0 = wr_count;
        slb_drive(32'h600, 32'h11223344, 1'b1, 2'b00);
        tick();
        bus.is_empty_from_slb = 1'b1;
        tick();
        chk("rstmid_wr_pre", 32'(bus.mem_wr), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid_wr", 32'(bus.mem_wr), 32'h0);
        chk("rstmid_a", 32'(bus.mem_a), 32'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rstmid_ram_600", 32'(ram[17'h600]), 32'h44);
        chk("rstmid_ram_601", 32'(ram[17'h601]), 32'h55);
        chk("rstmid_ram_602", 32'(ram[17'h602]), 32'h66);
        chk("rstmid_wr_cycles", wr_count - w0, 1);
        chk("rstmid_no_pulse", fin_count - f0, 0);
        chk("rstmid_idle", 32'(bus.is_stall_to_slb), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
